ram_writer: RTL and testbench

RAM_WRITER -- requirements
Module: ram_writer

---
 rtl/ram_writer_pkg.sv | 8 +
 rtl/ram_writer_if.sv | 24 ++
 rtl/ram_init_table.sv | 14 +
 rtl/ram_writer.sv | 57 +++++
 tb/tb_ram_writer.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/ram_writer_pkg.sv
// ram_writer_pkg: shared defaults, FSM state type and power-up table for ram_writer
package ram_writer_pkg;
  localparam int ADDR_WIDTH_DEF = 2;
  localparam int DATA_WIDTH_DEF = 4;
  localparam int DEPTH_DEF = 2 ** ADDR_WIDTH_DEF;
  typedef enum logic [1:0] {INIT, ACCEPT, FULL} state_t;
  localparam logic [15:0] INIT_TABLE = {4'b0111, 4'b0110, 4'b1100, 4'b0100};
endpackage

// File: rtl/ram_writer_if.sv
// ram_writer_if: write/read/status bundle; slave = ram_writer, master = its driver
// clear, wr_valid, wr_data, rd_addr flow master->slave; wr_ready, rd_data, wr_addr, count, full flow back
interface ram_writer_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 4
) ();
  logic clear;
  logic wr_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic wr_ready;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH:0] count;
  logic full;
  modport slave (
    input clear, wr_valid, wr_data, rd_addr,
    output wr_ready, rd_data, wr_addr, count, full
  );
  modport master (
    output clear, wr_valid, wr_data, rd_addr,
    input wr_ready, rd_data, wr_addr, count, full
  );
endinterface

// File: rtl/ram_init_table.sv
// ram_init_table: combinational address -> power-up word map (addr in, word out); repeats every 4 words
module ram_init_table
  import ram_writer_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] word
);
  logic [1:0] i;
  assign i = 2'(addr);
  assign word = DATA_WIDTH'(INIT_TABLE[4*i +: 4]);
endmodule

// File: rtl/ram_writer.sv
// ram_writer: register-array RAM preloaded from a table after reset, then filled by valid/ready writes
// Ports: clock, reset_n (async active-low); bus (slave) carries clear, write handshake, read port and status
module ram_writer
  import ram_writer_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input logic clock,
  input logic reset_n,
  ram_writer_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH:0] LAST_CNT = {1'b0, LAST_ADDR};
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] init_word;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH:0] count;
  logic accept;
  // wr_addr doubles as the INIT index; it wraps back to 0 as INIT ends
  ram_init_table #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_table (
    .addr(wr_addr),
    .word(init_word)
  );
  always_comb begin
    accept = state == ACCEPT && bus.wr_valid && !bus.clear;
    state_nx = state == INIT ? (wr_addr == LAST_ADDR ? ACCEPT : INIT)
             : bus.clear ? ACCEPT
             : accept && count == LAST_CNT ? FULL : state;
    bus.wr_ready = state == ACCEPT;
    bus.full = state == FULL;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= INIT;
    else state <= state_nx;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      mem <= '{default: '0};
      wr_addr <= '0;
      count <= '0;
    end else if (state == INIT) begin
      mem[wr_addr] <= init_word;
      wr_addr <= wr_addr + 1'b1;
    end else if (bus.clear) begin
      wr_addr <= '0;
      count <= '0;
    end else if (accept) begin
      mem[wr_addr] <= bus.wr_data;
      wr_addr <= wr_addr + 1'b1;
      count <= count + 1'b1;
    end
  assign bus.rd_data = mem[bus.rd_addr];
  assign bus.wr_addr = wr_addr;
  assign bus.count = count;
endmodule

// File: tb/tb_ram_writer.sv
// tb_ram_writer: directed self-checking bench for ram_writer
module tb_ram_writer;
  logic clock = 0;
  logic reset_n;
  int n_checks = 0;
  int n_fail = 0;
  ram_writer_if #(.ADDR_WIDTH(2), .DATA_WIDTH(4)) bus ();
  ram_writer #(.ADDR_WIDTH(2), .DATA_WIDTH(4)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );
  always #10 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic rd(input logic [1:0] a, input logic [3:0] exp, input string tag);
    bus.rd_addr = a;
    #1;
    chk(tag, 32'(bus.rd_data), 32'(exp));
  endtask
  task automatic status(input string tag, input logic rdy, input logic fl, input logic [2:0] cnt, input logic [1:0] wa);
    chk({tag, ".wr_ready"}, 32'(bus.wr_ready), 32'(rdy));
    chk({tag, ".full"}, 32'(bus.full), 32'(fl));
    chk({tag, ".count"}, 32'(bus.count), 32'(cnt));
    chk({tag, ".wr_addr"}, 32'(bus.wr_addr), 32'(wa));
  endtask
  initial begin
    reset_n = 0;
    bus.clear = 0;
    bus.wr_valid = 0;
    bus.wr_data = 0;
    bus.rd_addr = 0;
    step();
    step();
    status("reset", 0, 0, 0, 0);
    for (int a = 0; a < 4; a++) rd(2'(a), 4'h0, "reset.rd");
    // INIT: 4 edges, clear pulsed in the middle must be ignored
    reset_n = 1;
    step();
    chk("init1.wr_ready", 32'(bus.wr_ready), 0);
    bus.clear = 1;
    step();
    chk("init2.wr_ready", 32'(bus.wr_ready), 0);
    bus.clear = 0;
    step();
    status("init3", 0, 0, 0, 3);
    step();
    status("init_done", 1, 0, 0, 0);
    rd(0, 4'b0100, "table0");
    rd(1, 4'b1100, "table1");
    rd(2, 4'b0110, "table2");
    rd(3, 4'b0111, "table3");
    // fill with A,B,C,D back-to-back
    bus.wr_valid = 1;
    bus.wr_data = 4'hA;
    step();
    bus.wr_data = 4'hB;
    step();
    status("fill2", 1, 0, 2, 2);
    bus.wr_data = 4'hC;
    step();
    bus.wr_data = 4'hD;
    step();
    bus.wr_valid = 0;
    status("filled", 0, 1, 4, 0);
    rd(0, 4'hA, "fill.m0");
    rd(1, 4'hB, "fill.m1");
    rd(2, 4'hC, "fill.m2");
    rd(3, 4'hD, "fill.m3");
    // write while FULL is ignored
    bus.wr_valid = 1;
    bus.wr_data = 4'hE;
    step();
    bus.wr_valid = 0;
    status("full_wr", 0, 1, 4, 0);
    rd(0, 4'hA, "full_wr.m0");
    rd(1, 4'hB, "full_wr.m1");
    // clear from FULL, then write 3
    bus.clear = 1;
    step();
    bus.clear = 0;
    status("clr_full", 1, 0, 0, 0);
    bus.wr_valid = 1;
    bus.wr_data = 4'h3;
    step();
    bus.wr_valid = 0;
    status("after_clr_wr", 1, 0, 1, 1);
    rd(0, 4'h3, "after_clr.m0");
    rd(1, 4'hB, "after_clr.m1");
    rd(2, 4'hC, "after_clr.m2");
    rd(3, 4'hD, "after_clr.m3");
    // read-during-write at address 1
    bus.rd_addr = 1;
    bus.wr_valid = 1;
    bus.wr_data = 4'h9;
    #1;
    chk("rdw.old", 32'(bus.rd_data), 32'hB);
    step();
    bus.wr_valid = 0;
    chk("rdw.new", 32'(bus.rd_data), 32'h9);
    status("rdw", 1, 0, 2, 2);
    // clear and write together: clear wins
    bus.clear = 1;
    bus.wr_valid = 1;
    bus.wr_data = 4'hF;
    step();
    bus.clear = 0;
    bus.wr_valid = 0;
    status("conflict", 1, 0, 0, 0);
    rd(2, 4'hC, "conflict.m2");
    rd(0, 4'h3, "conflict.m0");
    bus.wr_valid = 1;
    bus.wr_data = 4'h5;
    step();
    bus.wr_valid = 0;
    rd(0, 4'h5, "post_conflict.m0");
    status("post_conflict", 1, 0, 1, 1);
    // wr_valid dropped: no change
    step();
    status("idle", 1, 0, 1, 1);
    // reset, then a second reset mid-INIT
    reset_n = 0;
    #1;
    status("reset2", 0, 0, 0, 0);
    for (int a = 0; a < 4; a++) rd(2'(a), 4'h0, "reset2.rd");
    reset_n = 1;
    step();
    step();
    rd(1, 4'b1100, "midinit.m1");
    reset_n = 0;
    #1;
    status("midreset", 0, 0, 0, 0);
    rd(0, 4'h0, "midreset.m0");
    rd(1, 4'h0, "midreset.m1");
    reset_n = 1;
    step();
    step();
    step();
    chk("restart3.wr_ready", 32'(bus.wr_ready), 0);
    step();
    status("restart_done", 1, 0, 0, 0);
    rd(0, 4'b0100, "restart.m0");
    rd(3, 4'b0111, "restart.m3");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
